if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Parametrised successor to the single-entry IF pipeline register: a DEPTH-entry FIFO between fetch and decode.
- Each entry holds one fetch bundle: FETCH_WIDTH consecutive instructions plus the bundle PC and a per-lane valid mask.
- Absorbs the one-cycle synchronous instruction-memory latency, applies backpressure with in-flight accounting, and supports single-cycle flush that also kills the in-flight response.
- Decode dequeues one bundle per cycle through a valid/ready handshake.

Parameters:
- PC_WIDTH, 32, PC width in bits.
- WORD_WIDTH, 32, instruction width in bits.
- FETCH_WIDTH, 2, instructions per bundle. Lane i PC = bundle PC + 4*i.
- DEPTH, 4, queue entries. Power of two, ≥2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cpu_en  in  1  core enable
- flush  in  1  discard all queued and in-flight bundles
- fetch_valid  in  1  fetch request presented this cycle
- fetch_pc  in  PC_WIDTH  bundle PC of request
- fetch_mask  in  FETCH_WIDTH  lane-valid mask of request
- fetch_ready  out  1  request accepted when fetch_valid & fetch_ready
- mem_insn  in  FETCH_WIDTH*WORD_WIDTH  memory data; lane i at bits [i*WORD_WIDTH +: WORD_WIDTH]; valid the cycle after acceptance
- out_valid  out  1  head bundle valid
- out_pc  out  PC_WIDTH  head bundle PC
- out_insn  out  FETCH_WIDTH*WORD_WIDTH  head bundle instructions
- out_mask  out  FETCH_WIDTH  head lane mask
- out_ready  in  1  decode consumes head when out_valid & out_ready
- count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (async, rst_n=0): all of the following clear immediately, regardless of clk.
  - count, head/tail pointers, in-flight flag, out_valid = 0.
  - out_pc, out_insn, out_mask = 0.
- Combinational outputs:
  - fetch_ready = cpu_en & ~flush & (count + inflight < DEPTH). It does not depend on out_ready (no comb path deq→fetch).
  - out_valid = cpu_en & ~flush & (count != 0).
  - out_pc / out_insn / out_mask come from the head entry when count != 0; all-zero when empty.
- Accept, cycle N:
  - Register fetch_pc and fetch_mask, and set inflight = 1.
  - With no accept in cycle N, inflight is 0 in cycle N+1.
- Response, cycle N+1:
  - If inflight & ~flush & (pending mask != 0): write {pc, mem_insn, mask} at tail and advance tail (mod DEPTH).
  - A mask of 0 is consumed silently; no entry is written.
- Latency: a request accepted in cycle N is visible at out_* in cycle N+2 at the earliest.
- Dequeue when out_valid & out_ready: advance head (mod DEPTH).
- count update:
  - Enqueue and dequeue in the same cycle: count unchanged.
  - Enqueue only: +1. Dequeue only: −1.
- Overflow is impossible by construction: accept requires count + inflight < DEPTH.
- flush=1 in cycle F:
  - No accept and no dequeue in F.
  - Any response arriving in F is discarded.
  - head = tail = 0, count = 0, inflight = 0 at the F+1 edge.
  - Requests accepted in F−1 are therefore dropped.
- cpu_en=0:
  - fetch_ready = 0 and out_valid = 0, so there are no accepts and no dequeues.
  - A response already in flight is still enqueued (memory cannot be stalled).
  - Contents are retained until cpu_en returns.
- Pointer wrap: head/tail wrap DEPTH−1→0. Full (count == DEPTH) and empty (count == 0) are distinguished by count, not by pointer equality.

Test Plan:
- Reset: assert rst_n=0 mid-stream with count=3 → count=0, out_valid=0, out_* = 0 immediately. After release with cpu_en=1 → fetch_ready=1.
- Latency/order: accept pc=0x100, mask=2'b11 in cycle 0; mem_insn={0x00200093,0x00100013} in cycle 1 → cycle 2: out_valid=1, out_pc=0x100, lane0=0x00100013, lane1=0x00200093, out_mask=2'b11.
- Fill/backpressure (DEPTH=4, out_ready=0): stream pc 0x0,0x8,0x10,… → exactly 4 accepts, then fetch_ready=0 with count+inflight=4. Draining with out_ready=1 yields pcs 0x0,0x8,0x10,0x18 in order, spanning a wrap of the tail pointer.
- Simultaneous enq/deq: at count=2 with a response arriving and out_ready=1 → count stays 2 and the next head pc is correct.
- Flush: count=3 plus one in-flight, pulse flush → next cycle count=0 and out_valid=0; the in-flight data never appears. Fetch pc=0x200 afterwards → only 0x200 is output.
- cpu_en / mask: deassert cpu_en with a response in flight → count +1, out_valid=0, fetch_ready=0; re-enable → bundle presented. A fetch with mask=2'b00 → count unchanged.

Source files
------------

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_queue
// Description : DEPTH-entry fetch queue sitting between instruction fetch and
//               decode. Each entry holds one fetch bundle: FETCH_WIDTH
//               consecutive instructions, the bundle PC and a per-lane valid
//               mask. The queue absorbs the one-cycle instruction-memory
//               latency. It applies backpressure that counts the in-flight
//               response, and it supports a single-cycle flush that also
//               kills that response.
//
// Ports       : clk          - clock
//               rst_n        - asynchronous active-low reset
//               cpu_en       - core enable (gates accepts and dequeues)
//               flush        - discard queued and in-flight bundles
//               fetch_valid  - fetch request presented
//               fetch_pc     - bundle PC of the request
//               fetch_mask   - lane-valid mask of the request
//               fetch_ready  - request accepted when fetch_valid & fetch_ready
//               mem_insn     - memory data, valid the cycle after an accept
//               out_valid    - head bundle valid
//               out_pc       - head bundle PC
//               out_insn     - head bundle instructions (lane i at i*WORD_WIDTH)
//               out_mask     - head bundle lane mask
//               out_ready    - decode consumes head when out_valid & out_ready
//               count        - number of occupied entries
//
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
    parameter int PC_WIDTH    = 32,
    parameter int WORD_WIDTH  = 32,
    parameter int FETCH_WIDTH = 2,
    parameter int DEPTH       = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cpu_en,
    input  logic                              flush,
    input  logic                              fetch_valid,
    input  logic [PC_WIDTH-1:0]               fetch_pc,
    input  logic [FETCH_WIDTH-1:0]            fetch_mask,
    output logic                              fetch_ready,
    input  logic [FETCH_WIDTH*WORD_WIDTH-1:0] mem_insn,
    output logic                              out_valid,
    output logic [PC_WIDTH-1:0]               out_pc,
    output logic [FETCH_WIDTH*WORD_WIDTH-1:0] out_insn,
    output logic [FETCH_WIDTH-1:0]            out_mask,
    input  logic                              out_ready,
    output logic [$clog2(DEPTH+1)-1:0]        count
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_PTR_W    = $clog2(DEPTH);
    localparam int c_CNT_W    = $clog2(DEPTH+1);
    localparam int c_OCC_W    = c_CNT_W + 1;
    localparam int c_BUNDLE_W = FETCH_WIDTH * WORD_WIDTH;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_PTR_W-1:0]     r_head;
    logic [c_PTR_W-1:0]     r_tail;
    logic [c_CNT_W-1:0]     r_count;
    logic                   r_inflight;
    logic [PC_WIDTH-1:0]    r_pend_pc;
    logic [FETCH_WIDTH-1:0] r_pend_mask;

    // Entry storage. It is not reset: an entry is only observable once it
    // has been written, because the output mux forces zero when empty.
    logic [PC_WIDTH-1:0]    r_pc_mem   [DEPTH];
    logic [c_BUNDLE_W-1:0]  r_insn_mem [DEPTH];
    logic [FETCH_WIDTH-1:0] r_mask_mem [DEPTH];

    // ------------------------------------------------------------------------
    // Handshake and control decode
    // ------------------------------------------------------------------------
    logic [c_OCC_W-1:0] w_occupancy;
    logic               w_room;
    logic               w_empty;
    logic               w_accept;
    logic               w_deq;
    logic               w_enq;

    // The in-flight response is reserved as if it already held a slot. That
    // is why an accepted request can never find the queue full when its data
    // returns.
    assign w_occupancy = {1'b0, r_count} + c_OCC_W'(r_inflight);
    assign w_room      = (w_occupancy < c_OCC_W'(DEPTH));
    assign w_empty     = (r_count == '0);

    // fetch_ready deliberately ignores out_ready. That keeps any
    // combinational path from decode back to fetch out of the design.
    assign fetch_ready = cpu_en & ~flush & w_room;
    assign out_valid   = cpu_en & ~flush & ~w_empty;

    assign w_accept    = fetch_valid & fetch_ready;
    assign w_deq       = out_valid & out_ready;

    // Memory cannot be stalled, so a pending response is written even while
    // cpu_en is low. Only flush discards it. A zero mask means the request
    // carried no useful lanes, and it is dropped without using an entry.
    assign w_enq       = r_inflight & ~flush & (r_pend_mask != '0);

    // ------------------------------------------------------------------------
    // Pending-request tracking
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight  <= 1'b0;
            r_pend_pc   <= '0;
            r_pend_mask <= '0;
        end else if (flush) begin
            r_inflight  <= 1'b0;
        end else begin
            // One-cycle memory: the flag lives for exactly one cycle after
            // each accept.
            r_inflight <= w_accept;
            if (w_accept) begin
                r_pend_pc   <= fetch_pc;
                r_pend_mask <= fetch_mask;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------------
    // Pointers are exactly log2(DEPTH) bits, so they wrap DEPTH-1 -> 0 for
    // free. Full and empty are told apart by r_count and not by comparing
    // the pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (w_deq) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Entry write
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_pc_mem[r_tail]   <= r_pend_pc;
            r_insn_mem[r_tail] <= mem_insn;
            r_mask_mem[r_tail] <= r_pend_mask;
        end
    end

    // ------------------------------------------------------------------------
    // Head presentation
    // ------------------------------------------------------------------------
    // The outputs are zero whenever the queue is empty. This includes the
    // time rst_n is held low, because r_count clears asynchronously.
    assign out_pc   = w_empty ? '0 : r_pc_mem[r_head];
    assign out_insn = w_empty ? '0 : r_insn_mem[r_head];
    assign out_mask = w_empty ? '0 : r_mask_mem[r_head];
    assign count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_queue
// Description : Directed self-checking bench for if_fetch_queue (DEPTH=4,
//               FETCH_WIDTH=2). Inputs change 1 ns after each rising edge,
//               and outputs are checked 1 ns later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;

    localparam int PC_WIDTH    = 32;
    localparam int WORD_WIDTH  = 32;
    localparam int FETCH_WIDTH = 2;
    localparam int DEPTH       = 4;
    localparam int CW          = $clog2(DEPTH+1);

    logic                              clk;
    logic                              rst_n;
    logic                              cpu_en;
    logic                              flush;
    logic                              fetch_valid;
    logic [PC_WIDTH-1:0]               fetch_pc;
    logic [FETCH_WIDTH-1:0]            fetch_mask;
    logic                              fetch_ready;
    logic [FETCH_WIDTH*WORD_WIDTH-1:0] mem_insn;
    logic                              out_valid;
    logic [PC_WIDTH-1:0]               out_pc;
    logic [FETCH_WIDTH*WORD_WIDTH-1:0] out_insn;
    logic [FETCH_WIDTH-1:0]            out_mask;
    logic                              out_ready;
    logic [CW-1:0]                     count;

    int n_cmp;
    int n_err;

    if_fetch_queue #(
        .PC_WIDTH    (PC_WIDTH),
        .WORD_WIDTH  (WORD_WIDTH),
        .FETCH_WIDTH (FETCH_WIDTH),
        .DEPTH       (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_en      (cpu_en),
        .flush       (flush),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_mask  (fetch_mask),
        .fetch_ready (fetch_ready),
        .mem_insn    (mem_insn),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_insn    (out_insn),
        .out_mask    (out_mask),
        .out_ready   (out_ready),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns a recognisable pattern per PC: lane0 = A000_0000|pc and
    // lane1 = B000_0000|pc.
    function automatic logic [63:0] data(input logic [31:0] pc);
        return {32'hB000_0000 | pc, 32'hA000_0000 | pc};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    logic [31:0] next_pc;
    logic [31:0] last_pc;
    int          acc;

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; cpu_en = 1'b0; flush = 1'b0; fetch_valid = 1'b0;
        fetch_pc = '0; fetch_mask = '0; mem_insn = '0; out_ready = 1'b0;
        #2;
        check("rst_count",       count,       0);
        check("rst_out_valid",   out_valid,   0);
        check("rst_fetch_ready", fetch_ready, 0);
        check("rst_out_pc",      out_pc,      0);
        tick; tick;
        rst_n = 1'b1; cpu_en = 1'b1; settle;
        check("post_rst_fetch_ready", fetch_ready, 1);

        // ---------------- latency / lane order ----------------
        fetch_valid = 1'b1; fetch_pc = 32'h100; fetch_mask = 2'b11; settle;
        check("lat_accept_ready", fetch_ready, 1);
        tick;
        fetch_valid = 1'b0; mem_insn = {32'h00200093, 32'h00100013}; settle;
        check("lat_c1_out_valid", out_valid, 0);
        tick;
        mem_insn = '0; settle;
        check("lat_c2_out_valid", out_valid, 1);
        check("lat_c2_out_pc",    out_pc,    32'h100);
        check("lat_c2_lane0",     out_insn[31:0],  32'h00100013);
        check("lat_c2_lane1",     out_insn[63:32], 32'h00200093);
        check("lat_c2_out_mask",  out_mask,  2'b11);
        check("lat_c2_count",     count,     1);
        out_ready = 1'b1; tick;
        out_ready = 1'b0; settle;
        check("lat_drained_count", count, 0);

        // ---------------- fill / backpressure ----------------
        next_pc = 32'h0; last_pc = 32'h0; acc = 0;
        for (int i = 0; i < 6; i++) begin
            fetch_valid = 1'b1; fetch_pc = next_pc; fetch_mask = 2'b11;
            mem_insn = data(last_pc); settle;
            check("fill_ready", fetch_ready, (i < 4) ? 1 : 0);
            if (i == 4) check("fill_count_at_stall", count, 3);
            if (fetch_ready) begin
                acc++;
                last_pc = next_pc;
                next_pc = next_pc + 32'h8;
            end
            tick;
        end
        fetch_valid = 1'b0; settle;
        check("fill_accepts",     acc,         4);
        check("fill_full_count",  count,       4);
        check("fill_full_ready",  fetch_ready, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_valid", out_valid, 1);
            check("drain_pc",    out_pc,    32'(k * 8));
            check("drain_insn",  out_insn,  data(32'(k * 8)));
            tick;
        end
        out_ready = 1'b0; settle;
        check("drain_empty_count", count,     0);
        check("drain_empty_valid", out_valid, 0);

        // ---------------- simultaneous enqueue / dequeue ----------------
        fetch_valid = 1'b1; fetch_pc = 32'h300; tick;
        fetch_pc = 32'h308; mem_insn = data(32'h300); tick;
        fetch_pc = 32'h310; mem_insn = data(32'h308); tick;
        fetch_valid = 1'b0; mem_insn = data(32'h310); out_ready = 1'b1; settle;
        check("sim_pre_count", count,  2);
        check("sim_pre_pc",    out_pc, 32'h300);
        tick;
        out_ready = 1'b0;
        fetch_valid = 1'b1; fetch_pc = 32'h318; settle;
        check("sim_post_count", count,  2);
        check("sim_post_pc",    out_pc, 32'h308);
        tick;
        fetch_pc = 32'h320; mem_insn = data(32'h318); tick;

        // ---------------- flush ----------------
        fetch_valid = 1'b0; mem_insn = data(32'h320); flush = 1'b1; settle;
        check("flush_pre_count", count,       3);
        check("flush_ready",     fetch_ready, 0);
        check("flush_out_valid", out_valid,   0);
        tick;
        flush = 1'b0; mem_insn = '0; settle;
        check("flush_count",     count,     0);
        check("flush_valid",     out_valid, 0);
        check("flush_out_pc",    out_pc,    0);
        fetch_valid = 1'b1; fetch_pc = 32'h200; fetch_mask = 2'b11; tick;
        fetch_valid = 1'b0; mem_insn = data(32'h200); tick;
        settle;
        check("post_flush_count", count,    1);
        check("post_flush_pc",    out_pc,   32'h200);
        check("post_flush_insn",  out_insn, data(32'h200));
        out_ready = 1'b1; tick;
        out_ready = 1'b0; settle;
        check("post_flush_drain", count, 0);

        // ---------------- cpu_en ----------------
        fetch_valid = 1'b1; fetch_pc = 32'h400; tick;
        cpu_en = 1'b0; fetch_pc = 32'h408; mem_insn = data(32'h400); settle;
        check("dis_ready", fetch_ready, 0);
        tick;
        check("dis_count",     count,       1);
        check("dis_out_valid", out_valid,   0);
        check("dis_ready2",    fetch_ready, 0);
        tick;
        check("dis_count_hold", count, 1);
        cpu_en = 1'b1; fetch_valid = 1'b0; out_ready = 1'b1; settle;
        check("en_out_valid", out_valid, 1);
        check("en_out_pc",    out_pc,    32'h400);
        tick;
        out_ready = 1'b0;

        // ---------------- zero mask ----------------
        fetch_valid = 1'b1; fetch_pc = 32'h500; fetch_mask = 2'b00; settle;
        check("mask0_pre_count", count,       0);
        check("mask0_ready",     fetch_ready, 1);
        tick;
        fetch_valid = 1'b0; fetch_mask = 2'b11; mem_insn = data(32'h500); tick;
        settle;
        check("mask0_count", count,     0);
        check("mask0_valid", out_valid, 0);

        // ---------------- asynchronous reset mid-stream ----------------
        fetch_valid = 1'b1; fetch_pc = 32'h600; tick;
        fetch_pc = 32'h608; mem_insn = data(32'h600); tick;
        fetch_pc = 32'h610; mem_insn = data(32'h608); tick;
        fetch_valid = 1'b0; mem_insn = data(32'h610); tick;
        settle;
        check("arst_pre_count", count,  3);
        check("arst_pre_pc",    out_pc, 32'h600);
        rst_n = 1'b0; #1;
        check("arst_count",     count,     0);
        check("arst_out_valid", out_valid, 0);
        check("arst_out_pc",    out_pc,    0);
        check("arst_out_insn",  out_insn,  0);
        check("arst_out_mask",  out_mask,  0);
        tick;
        rst_n = 1'b1; settle;
        check("arst_release_ready", fetch_ready, 1);
        check("arst_release_count", count,       0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
